// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the issuing control logic and the RV32M multiply/divide unit.
interface muldiv_unit_if;
    localparam int unsigned XLEN = 32;

    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] opA;
    logic [XLEN-1:0] opB;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (output start, funct3, opA, opB, input busy, done, result);
    modport slave  (input start, funct3, opA, opB, output busy, done, result);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide, one bit per cycle,
// with divide-by-zero and signed overflow resolved at start in a single cycle.
module muldiv_unit (
    input  logic           clk,
    input  logic           rst_n,
    muldiv_unit_if.slave   bus
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned CW   = 6;
    localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t            state_q;
    logic [2:0]        f3_q;
    logic              sign_a_q, sign_b_q, special_q;
    logic [XLEN-1:0]   mag_a_q, mag_b_q;
    logic [CW-1:0]     cnt_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   rem_q;
    logic              busy_q, done_q;
    logic [XLEN-1:0]   result_q;

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

    // Operand decode for an incoming request
    logic            sign_a_c, sign_b_c, div0_c, ovf_c, special_c;
    logic [XLEN-1:0] mag_a_c, mag_b_c, special_res_c;

    always_comb begin
        sign_a_c = 1'b0;
        sign_b_c = 1'b0;
        case (bus.funct3)
            3'b001, 3'b100, 3'b110: begin
                sign_a_c = bus.opA[XLEN-1];
                sign_b_c = bus.opB[XLEN-1];
            end
            3'b010:  sign_a_c = bus.opA[XLEN-1];
            default: ;
        endcase
        mag_a_c = sign_a_c ? (XLEN'(0) - bus.opA) : bus.opA;
        mag_b_c = sign_b_c ? (XLEN'(0) - bus.opB) : bus.opB;
        div0_c  = bus.funct3[2] && (bus.opB == '0);
        ovf_c   = bus.funct3[2] && !bus.funct3[0] &&
                  (bus.opA == XLEN'(32'h8000_0000)) && (bus.opB == '1);
        special_c = div0_c || ovf_c;
        if (div0_c) special_res_c = bus.funct3[1] ? bus.opA : '1;
        else        special_res_c = bus.funct3[1] ? '0 : XLEN'(32'h8000_0000);
    end

    // One iteration step of each datapath plus the sign-corrected final results
    logic [XLEN:0]     mul_sum_c, div_shift_c;
    logic [2*XLEN-1:0] mul_d, prod_c;
    logic              div_ge_c;
    logic [XLEN-1:0]   rem_d, quo_d, mul_res_c, div_res_c;

    always_comb begin
        mul_sum_c   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? mag_a_q : '0)};
        mul_d       = {mul_sum_c, acc_q[XLEN-1:1]};
        prod_c      = (sign_a_q ^ sign_b_q) ? ((2*XLEN)'(0) - mul_d) : mul_d;
        mul_res_c   = (f3_q == 3'b000) ? prod_c[XLEN-1:0] : prod_c[2*XLEN-1:XLEN];

        div_shift_c = {rem_q, acc_q[XLEN-1]};
        div_ge_c    = div_shift_c >= {1'b0, mag_b_q};
        rem_d       = XLEN'(div_ge_c ? (div_shift_c - {1'b0, mag_b_q}) : div_shift_c);
        quo_d       = {acc_q[XLEN-2:0], div_ge_c};
        if (f3_q[1]) div_res_c = sign_a_q ? (XLEN'(0) - rem_d) : rem_d;
        else         div_res_c = (sign_a_q ^ sign_b_q) ? (XLEN'(0) - quo_d) : quo_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            f3_q      <= '0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            special_q <= 1'b0;
            mag_a_q   <= '0;
            mag_b_q   <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        f3_q      <= bus.funct3;
                        sign_a_q  <= sign_a_c;
                        sign_b_q  <= sign_b_c;
                        mag_a_q   <= mag_a_c;
                        mag_b_q   <= mag_b_c;
                        cnt_q     <= '0;
                        rem_q     <= '0;
                        busy_q    <= 1'b1;
                        special_q <= special_c;
                        // Low half of acc_q holds the multiplier, the dividend, or the special result
                        if (special_c) begin
                            acc_q   <= {{XLEN{1'b0}}, special_res_c};
                            state_q <= S_DIV;
                        end else if (bus.funct3[2]) begin
                            acc_q   <= {{XLEN{1'b0}}, mag_a_c};
                            state_q <= S_DIV;
                        end else begin
                            acc_q   <= {{XLEN{1'b0}}, mag_b_c};
                            state_q <= S_MUL;
                        end
                    end
                end
                S_MUL: begin
                    acc_q <= mul_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST_ITER) begin
                        result_q <= mul_res_c;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                S_DIV: begin
                    if (special_q) begin
                        result_q <= acc_q[XLEN-1:0];
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        rem_q            <= rem_d;
                        acc_q[XLEN-1:0]  <= quo_d;
                        cnt_q            <= cnt_q + CW'(1);
                        if (cnt_q == LAST_ITER) begin
                            result_q <= div_res_c;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    done_q    <= 1'b0;
                    special_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: results, latency, handshake corners and mid-operation reset.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    muldiv_unit_if bus ();
    muldiv_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request for one edge (E0); returns at the falling edge after E0
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = f3; bus.opA = a; bus.opB = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Counts edges after E0 until done is seen, flagging any cycle where busy is not high before it
    task automatic wait_done(input int max, output int lat, output bit busy_ok);
        bit found;
        found   = 1'b0;
        lat     = 0;
        busy_ok = (bus.busy === 1'b1);
        for (int i = 1; i <= max && !found; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done === 1'b1) begin
                found = 1'b1;
                lat   = i;
                if (bus.busy !== 1'b0) busy_ok = 1'b0;
            end else if (bus.busy !== 1'b1) begin
                busy_ok = 1'b0;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int lat;
        bit bok;
        issue(f3, a, b);
        wait_done(40, lat, bok);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, bus.result, exp_res);
        check({tag, "_busy"}, 32'(bok), 32'd1);
        @(negedge clk);
        check({tag, "_pulse"}, {bus.busy, bus.done}, 32'd0);
    endtask

    initial begin
        int lat;
        bit bok;
        int seen;
        bus.start = 1'b0; bus.funct3 = 3'b000; bus.opA = '0; bus.opB = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_result", bus.result, 32'h0);
        rst_n = 1'b1;

        // MUL 7 x -3 with operand change at cycle 5 and a stray start at cycle 10
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'b000; bus.opA = 32'd7; bus.opB = 32'hFFFF_FFFD;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0;
        bok = (bus.busy === 1'b1);
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done === 1'b1) lat = i;
            else if (bus.busy !== 1'b1) bok = 1'b0;
            if (i == 5)  bus.opA = 32'd123;
            if (i == 10) begin bus.start = 1'b1; bus.opB = 32'd5; end
            if (i == 11) bus.start = 1'b0;
        end
        check("mul_lat", 32'(lat), 32'd32);
        check("mul_res", bus.result, 32'hFFFF_FFEB);
        check("mul_busy", 32'(bok), 32'd1);

        // Start during the done cycle is dropped; held the next cycle it is taken
        bus.start = 1'b1; bus.funct3 = 3'b000; bus.opA = 32'd2; bus.opB = 32'd2;
        @(negedge clk);
        check("done_start_ignored", {bus.busy, bus.done}, 32'd0);
        check("done_start_result", bus.result, 32'hFFFF_FFEB);
        bus.funct3 = 3'b011; bus.opA = 32'hFFFF_FFFF; bus.opB = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b_accepted", 32'(bus.busy), 32'd1);
        wait_done(40, lat, bok);
        check("mulhu_lat", 32'(lat), 32'd32);
        check("mulhu_res", bus.result, 32'hFFFF_FFFE);
        @(negedge clk);

        run_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32);
        run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32);
        run_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32);
        run_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32);
        run_op("divu",   3'b101, 32'd100,       32'd7,         32'd14,        32);
        run_op("remu",   3'b111, 32'd100,       32'd7,         32'd2,         32);

        run_op("divu_z", 3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
        run_op("div_ov", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ov", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1);
        run_op("remu_z", 3'b111, 32'd5,         32'd0,         32'd5,         1);

        // Reset at cycle 15 of a DIV
        issue(3'b100, 32'hFFFF_FFF9, 32'd2);
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_state", {bus.busy, bus.done}, 32'd0);
        check("midrst_result", bus.result, 32'h0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen++;
        end
        check("midrst_no_done", 32'(seen), 32'd0);
        run_op("mul_after_rst", 3'b000, 32'd3, 32'd4, 32'd12, 32);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit sitting directly downstream of the register file. It takes the two source-operand read values (ruRs1, ruRs2) plus the instruction's funct3, and computes over multiple cycles. It returns a 32-bit result for the write-back path (dataWr) with a start/busy/done handshake. The control unit stalls the PC while busy is high.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
- start  input  1  request; sampled only in IDLE.
- funct3  input  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- opA  input  32  rs1 value (from ruRs1).
- opB  input  32  rs2 value (from ruRs2).
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; result valid.
- result  output  32  result; held until the next accepted start.

## Operation
- States:
  - IDLE: accepts start.
  - MUL: shift-add iteration.
  - DIV: restoring-division iteration.
  - DONE: done pulse.
- IDLE + start=1 latches the following:
  - funct3 and opA/opB.
  - Operand signs, per op. MULH, DIV and REM treat both operands as signed. MULHSU treats A as signed and B as unsigned. MUL and the U-variants treat both as unsigned.
  - Operand magnitudes in unsigned form, as |x|.
  - A 6-bit counter, cleared to 0.
- Later changes on opA/opB/funct3 are ignored until the next accepted start.
- Multiply path:
  - 64-bit product accumulator; one multiplier bit is consumed per cycle, LSB first.
  - 32 iterations.
  - The final product is negated if signA^signB.
  - MUL returns the low 32 bits; MULH, MULHSU and MULHU return the high 32 bits.
- Divide path:
  - Restoring algorithm: one quotient bit per cycle, MSB first, 33-bit partial remainder.
  - 32 iterations.
  - Quotient sign is signA^signB; remainder sign is signA.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Special cases are resolved at start and go straight to DONE with no iteration:
  - Divide by zero (opB==0): quotient 0xFFFFFFFF for both DIV and DIVU; remainder = opA.
  - Signed overflow (DIV/REM with opA=0x80000000, opB=0xFFFFFFFF): quotient 0x80000000, remainder 0.
- DONE: done=1 and result is updated for exactly one cycle, then the block returns to IDLE.
- start is ignored while busy=1.
- start in the DONE cycle is ignored. The earliest back-to-back start is the cycle after done.
- rst_n=0 at any edge, including mid-operation:
  - State goes to IDLE; busy=0, done=0, result=0, counter=0.
  - The in-flight operation is discarded.

## Timing
- Reset values: busy=0, done=0, result=0x00000000, state IDLE.
- Let E0 be the edge sampling start=1 in IDLE.
- Normal ops:
  - busy=1 after E0.
  - Iterations on edges E1..E32.
  - After E32: busy=0, done=1, result valid.
  - After E33: done=0, result held.
  - Latency is 32 cycles from start to done.
- Special-case divides: busy=1 after E0; after E1 busy=0, done=1. Latency 1.
- busy and done are never both 1.
- done is registered, with no combinational path from start.
- result changes only on the edge that raises done, or on reset.

## Test plan
- MUL: opA=7, opB=0xFFFFFFFD (-3). Required: done exactly 32 cycles after start, result=0xFFFFFFEB, busy high on cycles 1..32.
- High-half multiplies:
  - MULH 0x80000000×0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- Signed divide: DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- Corner cases (each must give done one cycle after start):
  - DIVU 5/0 -> 0xFFFFFFFF.
  - REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM with the same operands -> 0.
- Handshake:
  - Pulse start again at cycle 10 of a MUL with different operands -> ignored, original result returned.
  - Change opA at cycle 5 -> no effect.
  - Start in the DONE cycle -> ignored.
  - Start the cycle after done -> accepted.
- Reset at cycle 15 of a DIV -> busy=0, done=0, result=0 next cycle, and no done pulse follows. A new MUL 3×4 then returns 12 after 32 cycles.
